mseq_enc: RTL and testbench
===========================

Name: mseq_enc

Overview:
- Spreading transmitter and the encoder counterpart of the m-sequence correlator `dec`.
- Accepts bytes on a valid/ready handshake and sends each byte LSB first.
- Each data bit goes out as one 31-chip m-sequence period: the true sequence for bit 1, the inverted sequence for bit 0.
- The serial chip stream `signal` runs at one chip per `clk` and feeds `dec.signal` directly.

Parameters:
- TEMPLATE, 31'b0011001001111101110001010110100, the m-sequence; chip order is TEMPLATE[0] first, then [1] … [30].
- SEQ_LEN, 31, chips per bit period; fixed to the TEMPLATE width.
- IDLE_LEVEL, 1'b0, value driven on `signal` when no byte is in flight.

Ports:
- clk  input  1  chip clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  8  byte to send; sampled on handshake.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  block can accept a byte this cycle.
- signal  output  1  registered serial chip output.
- busy  output  1  a byte (or preamble) is on `signal`.
- sym_start  output  1  one-cycle pulse, high while the first chip of each bit period is on `signal`.
- byte_done  output  1  one-cycle pulse, high while the last chip of the byte is on `signal`.

Behaviour:
- Reset (async, active-high, applies immediately):
  - state=IDLE, chip_cnt=0, bit_cnt=0.
  - signal=IDLE_LEVEL, busy=0, sym_start=0, byte_done=0.
  - in_ready=0 while rst is high.
- Handshake: a byte is accepted on the rising edge where in_valid && in_ready.
  - in_ready = !rst && (state==IDLE || last), where last = (state==DATA && bit_cnt==7 && chip_cnt==30).
  - in_ready is combinational from state and counters, never from in_valid.
  - in_valid may drop without acceptance.
- Latency: the first chip appears on `signal` in the cycle after the handshake edge.
- Chip value: signal = TEMPLATE[chip_cnt] XOR ~shreg[0].
  - shreg holds the accepted byte and shifts right after chip 30 of each bit.
- FSM:
  - IDLE:
    - Accept → DATA, chip_cnt=0, bit_cnt=0.
    - Otherwise signal=IDLE_LEVEL.
  - DATA:
    - chip_cnt increments each cycle, wrapping 30→0.
    - On the wrap, bit_cnt increments.
    - At last with acceptance: reload shreg, counters go to 0, stay in DATA. No gap, so the stream is continuous.
    - At last without acceptance: → IDLE, and signal returns to IDLE_LEVEL the next cycle.
- Frame length: exactly 248 cycles per byte.
- busy = state!=IDLE.
- sym_start is high when chip_cnt==0 in DATA.
- byte_done = last.
- Counter widths: chip_cnt is 5 bits and never reaches 31; bit_cnt is 3 bits.
- Reset mid-byte: the byte is aborted and discarded with no resume; the next handshake starts at bit 0, chip 0.

Optional Feature:
- Macro: MSEQ_ENC_PREAMBLE_EN.
- Defined:
  - An accept goes to state PRE, which sends one unmodulated period (signal=TEMPLATE[chip_cnt], 31 cycles) before DATA.
  - sym_start pulses at PRE chip 0 as well.
  - Frame length is 279 cycles.
  - Back-to-back bytes also get a preamble each.
  - busy is high in PRE.
  - in_ready is low in PRE.
- Undefined: the PRE state and its logic are absent, and behaviour is exactly as above.

Decomposition:
- Package mfunc_pkg holds:
  - the TEMPLATE constant (shared with dec and benches);
  - SEQ_LEN=31 and BITS_PER_BYTE=8;
  - the state typedef enc_state_t {IDLE, PRE, DATA}.
- One sub-module, mseq_chip_gen:
  - owns chip_cnt and the TEMPLATE index;
  - outputs chip and wrap;
  - has inputs clear and enable.
- The top level holds the FSM, shreg, bit_cnt and the handshake.

Test Plan:
- Reset: hold rst for 3 cycles, then release → signal=0, busy=0, in_ready=0 during rst and 1 after; mid-reset assertion forces signal=0 without waiting for a clock edge.
- Send 8'hFF → 248 chips equal TEMPLATE repeated 8×, LSB first. First chip=0 (TEMPLATE[0]). sym_start at cycles 1, 32, 63 …; byte_done at cycle 248; busy drops at cycle 249.
- Send 8'hA5 → bit periods in order true, inverted, true, inverted, inverted, true, inverted, true; 8'h00 gives all 8 periods equal to ~TEMPLATE.
- Hold in_valid high with bytes 8'h01, 8'h02 → second accept on chip 248 of the first byte. No IDLE cycle, 496 contiguous chips; in_ready high only in that one DATA cycle.
- Assert rst at chip 100 of a byte → signal=0 and busy=0 immediately. The next byte 8'hFF restarts at TEMPLATE[0], with byte_done 248 cycles after acceptance.
- With MSEQ_ENC_PREAMBLE_EN, send 8'h00 → 31 chips of TEMPLATE, then 8×~TEMPLATE (279 cycles). Looped into dec, buff_wr equals TEMPLATE at the preamble end.

Source files
------------

// File: rtl/mfunc_pkg.sv
// Shared constants and types for the m-sequence spreading encoder/correlator pair.
package mfunc_pkg;

  localparam int unsigned SEQ_LEN       = 31;
  localparam int unsigned BITS_PER_BYTE = 8;
  localparam int unsigned CHIP_W        = $clog2(SEQ_LEN);
  localparam int unsigned BIT_W         = $clog2(BITS_PER_BYTE);

  // Chip order is TEMPLATE[0] first.
  localparam logic [SEQ_LEN-1:0] TEMPLATE   = 31'b0011001001111101110001010110100;
  localparam logic               IDLE_LEVEL = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2
  } enc_state_t;

endpackage

// File: rtl/mseq_chip_gen.sv
// Chip counter over one m-sequence period; chip_o and cnt_nxt_o describe the chip
// that will be on the line in the next cycle so the top can register its output.
module mseq_chip_gen
  import mfunc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  output logic              chip_o,
  output logic              wrap_o,
  output logic [CHIP_W-1:0] cnt_nxt_o
);

  logic [CHIP_W-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == CHIP_W'(SEQ_LEN - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = wrap_o ? '0 : cnt_q + CHIP_W'(1);
    end
  end

  assign cnt_nxt_o = cnt_d;
  assign chip_o    = TEMPLATE[cnt_d];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mseq_enc.sv
// m-sequence spreading transmitter: one 31-chip period per data bit, LSB first.
// Optional MSEQ_ENC_PREAMBLE_EN prepends one unmodulated period to every byte.
module mseq_enc
  import mfunc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       signal,
  output logic       busy,
  output logic       sym_start,
  output logic       byte_done
);

  enc_state_t        state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              signal_d, busy_d, sym_start_d, byte_done_d;
  logic              chip_nxt, wrap;
  logic [CHIP_W-1:0] cnt_nxt;
  logic              last_c, accept_c;

  mseq_chip_gen u_chip_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_q == IDLE),
    .enable    (state_q != IDLE),
    .chip_o    (chip_nxt),
    .wrap_o    (wrap),
    .cnt_nxt_o (cnt_nxt)
  );

  assign last_c   = (state_q == DATA) && (bit_cnt_q == BIT_W'(BITS_PER_BYTE - 1)) && wrap;
  assign in_ready = !rst && ((state_q == IDLE) || last_c);
  assign accept_c = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef MSEQ_ENC_PREAMBLE_EN
        if (accept_c) state_d = PRE;
`else
        if (accept_c) state_d = DATA;
`endif
      end
`ifdef MSEQ_ENC_PREAMBLE_EN
      PRE: begin
        if (wrap) state_d = DATA;
      end
`endif
      DATA: begin
        if (last_c) begin
`ifdef MSEQ_ENC_PREAMBLE_EN
          state_d = accept_c ? PRE : IDLE;
`else
          state_d = accept_c ? DATA : IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values, computed from the next state so the
  // registered outputs always describe the chip currently on the line.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    signal_d    = IDLE_LEVEL;
    busy_d      = 1'b0;
    sym_start_d = 1'b0;
    byte_done_d = 1'b0;

    if (accept_c) begin
      bit_cnt_d = '0;
      shreg_d   = data_in;
    end else if ((state_q == DATA) && wrap) begin
      bit_cnt_d = bit_cnt_q + BIT_W'(1);
      shreg_d   = {1'b0, shreg_q[7:1]};
    end

    case (state_d)
`ifdef MSEQ_ENC_PREAMBLE_EN
      PRE: begin
        signal_d    = chip_nxt;
        busy_d      = 1'b1;
        sym_start_d = (cnt_nxt == '0);
      end
`endif
      DATA: begin
        signal_d    = chip_nxt ^ ~shreg_d[0];
        busy_d      = 1'b1;
        sym_start_d = (cnt_nxt == '0);
        byte_done_d = (bit_cnt_d == BIT_W'(BITS_PER_BYTE - 1)) &&
                      (cnt_nxt == CHIP_W'(SEQ_LEN - 1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      signal    <= IDLE_LEVEL;
      busy      <= 1'b0;
      sym_start <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      signal    <= signal_d;
      busy      <= busy_d;
      sym_start <= sym_start_d;
      byte_done <= byte_done_d;
    end
  end

endmodule

// File: tb/tb_mseq_enc.sv
// Directed bench for mseq_enc; expected chips come from a hand-entered copy of the sequence.
module tb_mseq_enc;

`ifdef MSEQ_ENC_PREAMBLE_EN
  localparam int PRE_LEN = 31;
`else
  localparam int PRE_LEN = 0;
`endif
  localparam int FRAME = PRE_LEN + 248;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       in_valid;
  logic       in_ready, signal, busy, sym_start, byte_done;

  logic [30:0] tmpl;
  int nvec  = 0;
  int nfail = 0;

  mseq_enc dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .signal    (signal),
    .busy      (busy),
    .sym_start (sym_start),
    .byte_done (byte_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_chip(input logic [7:0] b, input int k);
    int n;
    n = k - 1 - PRE_LEN;
    if (k <= PRE_LEN) return tmpl[k-1];
    return tmpl[n % 31] ^ ~b[n / 31];
  endfunction

  task automatic idle_chk(input string tag);
    chk({tag, "_signal"}, signal, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_sym_start"}, sym_start, 1'b0);
    chk({tag, "_byte_done"}, byte_done, 1'b0);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  // Present a byte in IDLE and take the handshake edge; returns in frame cycle 1.
  task automatic start(input logic [7:0] b);
    data_in  = b;
    in_valid = 1'b1;
    chk("start_in_ready", in_ready, 1'b1);
    tick();
  endtask

  // Check one whole frame; when chain is set the next byte nb is accepted on its last cycle.
  task automatic frame(input logic [7:0] b, input bit chain, input logic [7:0] nb);
    for (int k = 1; k <= FRAME; k++) begin
      chk("signal", signal, exp_chip(b, k));
      chk("busy", busy, 1'b1);
      chk("sym_start", sym_start, ((k - 1) % 31) == 0);
      chk("byte_done", byte_done, k == FRAME);
      chk("in_ready", in_ready, k == FRAME);
      if (k == 1) begin
        in_valid = chain;
        data_in  = nb;
      end
      tick();
    end
  endtask

  initial begin
    tmpl     = 31'b0011001001111101110001010110100;
    rst      = 1'b0;
    in_valid = 1'b0;
    data_in  = 8'h00;

    // Reset behaviour
    #1 rst = 1'b1;
    #1;
    chk("rst_signal", signal, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_sym_start", sym_start, 1'b0);
    chk("rst_byte_done", byte_done, 1'b0);
    repeat (3) tick();
    chk("rst_hold_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle_chk("idle");
      tick();
    end

    // Single bytes: all-ones, alternating polarity, all-zeros
    start(8'hFF);
    frame(8'hFF, 1'b0, 8'h00);
    idle_chk("after_ff");
    start(8'hA5);
    frame(8'hA5, 1'b0, 8'h00);
    idle_chk("after_a5");
    start(8'h00);
    frame(8'h00, 1'b0, 8'h00);
    idle_chk("after_00");

    // Back-to-back bytes with in_valid held high
    start(8'h01);
    frame(8'h01, 1'b1, 8'h02);
    frame(8'h02, 1'b0, 8'h00);
    idle_chk("after_chain");

    // Reset in the middle of a byte
    start(8'hFF);
    for (int k = 1; k < 100; k++) begin
      chk("pre_abort_signal", signal, exp_chip(8'hFF, k));
      if (k == 1) in_valid = 1'b0;
      tick();
    end
    chk("abort_chip100", signal, exp_chip(8'hFF, 100));
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_signal", signal, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    chk("abort_sym_start", sym_start, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    idle_chk("post_abort");
    start(8'hFF);
    frame(8'hFF, 1'b0, 8'h00);
    idle_chk("after_restart");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
